fpu_resp_buffer: RTL and testbench

FPU_RESP_BUFFER -- requirements
Module: fpu_resp_buffer

---
 rtl/fpu_resp_buffer.sv | 147 ++++++++++++++
 tb/tb_fpu_resp_buffer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_resp_buffer.sv
// ---------------------------------------------------------------------------
// fpu_resp_buffer
//
// Credit-gated response buffer between a core and an FPU wrapper that has no
// result backpressure. A request may only be forwarded to the FPU while a
// response slot is reserved for it (inflight < DEPTH). FPU results are
// captured in a DEPTH-entry FIFO and handed to the core in arrival order.
//
// Handshakes: a request transfers when fpu_req_o && fpu_gnt_i are both high
// in the same cycle. A response transfers (pop) when core_rvalid_o &&
// core_rready_i are both high. core_rvalid_o never depends on core_rready_i.
// fpu_rvalid_i is a one-cycle strobe that cannot be stalled.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   core_req_i / core_gnt_o        core request and grant
//   fpu_req_o / fpu_gnt_i          gated request to FPU and FPU ready
//   fpu_rvalid_i, fpu_rdata_i,
//   fpu_rflags_i, fpu_rID_i        FPU result strobe and payload
//   core_rvalid_o / core_rready_i  buffered response handshake
//   core_rdata_o, core_rflags_o,
//   core_rID_o                     head-entry payload
//   busy_o                         requests in flight or buffered
//   overflow_o                     sticky: push dropped on a full buffer
// ---------------------------------------------------------------------------
module fpu_resp_buffer #(
    parameter int ID_WIDTH        = 9,
    parameter int DATA_WIDTH      = 32,
    parameter int FLAGS_OUT_WIDTH = 5,
    parameter int DEPTH           = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       core_req_i,
    output logic                       core_gnt_o,
    output logic                       fpu_req_o,
    input  logic                       fpu_gnt_i,
    input  logic                       fpu_rvalid_i,
    input  logic [DATA_WIDTH-1:0]      fpu_rdata_i,
    input  logic [FLAGS_OUT_WIDTH-1:0] fpu_rflags_i,
    input  logic [ID_WIDTH-1:0]        fpu_rID_i,
    output logic                       core_rvalid_o,
    input  logic                       core_rready_i,
    output logic [DATA_WIDTH-1:0]      core_rdata_o,
    output logic [FLAGS_OUT_WIDTH-1:0] core_rflags_o,
    output logic [ID_WIDTH-1:0]        core_rID_o,
    output logic                       busy_o,
    output logic                       overflow_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [CW-1:0] inflight_q, inflight_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [PW-1:0] wptr_q, wptr_d;
    logic          overflow_q, overflow_d;

    logic [DATA_WIDTH-1:0]      data_q  [DEPTH];
    logic [FLAGS_OUT_WIDTH-1:0] flags_q [DEPTH];
    logic [ID_WIDTH-1:0]        id_q    [DEPTH];

    logic space, accept, pop, full, push_ok;

    assign space      = (inflight_q < DEPTH_C);
    assign fpu_req_o  = core_req_i & space;
    assign core_gnt_o = fpu_gnt_i & space;
    assign accept     = fpu_req_o & fpu_gnt_i;

    assign core_rvalid_o = (count_q != '0);
    assign pop           = core_rvalid_o & core_rready_i;
    assign full          = (count_q == DEPTH_C);
    // A full buffer still accepts a push when the head leaves in the same
    // cycle: wptr == rptr then, and the slot being written is the one popped.
    assign push_ok       = fpu_rvalid_i & (~full | pop);

    assign core_rdata_o  = data_q[rptr_q];
    assign core_rflags_o = flags_q[rptr_q];
    assign core_rID_o    = id_q[rptr_q];
    assign busy_o        = (inflight_q != '0);
    assign overflow_o    = overflow_q;

    always_comb begin
        inflight_d = inflight_q;
        count_d    = count_q;
        rptr_d     = rptr_q;
        wptr_d     = wptr_q;
        overflow_d = overflow_q;

        // The zero guard keeps the credit count from wrapping if the FPU ever
        // returns a response that was never requested.
        if (accept && !pop) begin
            inflight_d = inflight_q + CW'(1);
        end else if (pop && !accept && inflight_q != '0) begin
            inflight_d = inflight_q - CW'(1);
        end

        if (push_ok && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push_ok) begin
            count_d = count_q - CW'(1);
        end

        if (pop) begin
            rptr_d = rptr_q + PW'(1);
        end
        if (push_ok) begin
            wptr_d = wptr_q + PW'(1);
        end
        if (fpu_rvalid_i && !push_ok) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q <= '0;
            count_q    <= '0;
            rptr_q     <= '0;
            wptr_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
            count_q    <= count_d;
            rptr_q     <= rptr_d;
            wptr_q     <= wptr_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i]  <= '0;
                flags_q[i] <= '0;
                id_q[i]    <= '0;
            end
        end else if (push_ok) begin
            data_q[wptr_q]  <= fpu_rdata_i;
            flags_q[wptr_q] <= fpu_rflags_i;
            id_q[wptr_q]    <= fpu_rID_i;
        end
    end

endmodule

// File: tb/tb_fpu_resp_buffer.sv
// ---------------------------------------------------------------------------
// tb_fpu_resp_buffer
//
// Testbench for fpu_resp_buffer. A reference model (response queue, credit
// count, sticky error bit) predicts every output each cycle; a vector table
// and directed sequences cover the single-operation, credit-stall, ordering,
// full-buffer and reset corner cases, followed by randomized traffic.
// ---------------------------------------------------------------------------
module tb_fpu_resp_buffer;

    localparam int IW    = 9;
    localparam int DW    = 32;
    localparam int FW    = 5;
    localparam int DEPTH = 4;
    localparam int W     = DW + FW + IW;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          core_req_i = 0, fpu_gnt_i = 0, fpu_rvalid_i = 0, core_rready_i = 0;
    logic [DW-1:0] fpu_rdata_i = '0;
    logic [FW-1:0] fpu_rflags_i = '0;
    logic [IW-1:0] fpu_rID_i = '0;
    logic          core_gnt_o, fpu_req_o, core_rvalid_o, busy_o, overflow_o;
    logic [DW-1:0] core_rdata_o;
    logic [FW-1:0] core_rflags_o;
    logic [IW-1:0] core_rID_o;

    fpu_resp_buffer #(
        .ID_WIDTH(IW), .DATA_WIDTH(DW), .FLAGS_OUT_WIDTH(FW), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .core_req_i(core_req_i), .core_gnt_o(core_gnt_o),
        .fpu_req_o(fpu_req_o), .fpu_gnt_i(fpu_gnt_i),
        .fpu_rvalid_i(fpu_rvalid_i), .fpu_rdata_i(fpu_rdata_i),
        .fpu_rflags_i(fpu_rflags_i), .fpu_rID_i(fpu_rID_i),
        .core_rvalid_o(core_rvalid_o), .core_rready_i(core_rready_i),
        .core_rdata_o(core_rdata_o), .core_rflags_o(core_rflags_o),
        .core_rID_o(core_rID_o), .busy_o(busy_o), .overflow_o(overflow_o)
    );

    // ---------------- scoreboard / model ----------------
    logic [W-1:0] exp_q[$];
    int  m_inflight = 0;
    bit  m_ovf = 0;
    bit  m_last_acc = 0;
    bit  m_last_pop = 0;
    int  n_checks = 0;
    int  n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Compare DUT against the model, then advance the model by one edge.
    task automatic model_step(input bit req, input bit gnt, input bit rv,
                              input logic [W-1:0] payload, input bit rr);
        bit space, acc, pop;
        logic [W-1:0] head;
        space = (m_inflight < DEPTH);
        chk("fpu_req_o", fpu_req_o, req && space);
        chk("core_gnt_o", core_gnt_o, gnt && space);
        chk("core_rvalid_o", core_rvalid_o, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
            head = exp_q[0];
            chk("core_rdata_o", core_rdata_o, head[W-1 -: DW]);
            chk("core_rflags_o", core_rflags_o, head[IW +: FW]);
            chk("core_rID_o", core_rID_o, head[IW-1:0]);
        end
        chk("busy_o", busy_o, m_inflight != 0);
        chk("overflow_o", overflow_o, m_ovf);

        acc = req && gnt && space;
        pop = (exp_q.size() != 0) && rr;
        if (pop) void'(exp_q.pop_front());
        if (rv) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(payload);
            else m_ovf = 1;
        end
        if (acc) m_inflight++;
        if (pop && m_inflight > 0) m_inflight--;
        m_last_acc = acc;
        m_last_pop = pop;
    endtask

    // ---------------- driver tasks ----------------
    // Inputs change 1 time unit after the rising edge; drive() returns at the
    // falling edge after checking, tick() moves to just past the next edge.
    task automatic drive(input bit req, input bit gnt, input bit rv,
                         input logic [DW-1:0] d, input logic [FW-1:0] f,
                         input logic [IW-1:0] id, input bit rr);
        core_req_i = req; fpu_gnt_i = gnt; fpu_rvalid_i = rv;
        fpu_rdata_i = d; fpu_rflags_i = f; fpu_rID_i = id; core_rready_i = rr;
        #4;
        model_step(req, gnt, rv, {d, f, id}, rr);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input bit req, input bit gnt, input bit rv,
                       input logic [IW-1:0] id, input bit rr);
        drive(req, gnt, rv, DW'(32'h4000_0000) + DW'(id), FW'(id), id, rr);
        tick();
    endtask

    task automatic do_reset();
        core_req_i = 1; fpu_gnt_i = 1; fpu_rvalid_i = 0; core_rready_i = 0;
        rst_n = 0;
        #1;
        chk("rst core_rvalid_o", core_rvalid_o, 0);
        chk("rst core_rdata_o", core_rdata_o, 0);
        chk("rst core_rflags_o", core_rflags_o, 0);
        chk("rst core_rID_o", core_rID_o, 0);
        chk("rst busy_o", busy_o, 0);
        chk("rst overflow_o", overflow_o, 0);
        chk("rst fpu_req_o", fpu_req_o, 1);
        chk("rst core_gnt_o", core_gnt_o, 1);
        exp_q.delete();
        m_inflight = 0;
        m_ovf = 0;
        core_req_i = 0; fpu_gnt_i = 0;
        @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    // ---------------- vector table: single operation ----------------
    typedef struct {
        bit req, gnt, rv, rr;
        logic [DW-1:0] d;
        logic [IW-1:0] id;
        bit e_req, e_gnt, e_rv, e_busy;
        logic [DW-1:0] e_d;
        logic [IW-1:0] e_id;
    } vec_t;

    vec_t vt[6];

    task automatic run_table();
        for (int i = 0; i < 6; i++) begin
            drive(vt[i].req, vt[i].gnt, vt[i].rv, vt[i].d, 5'h0, vt[i].id, vt[i].rr);
            chk($sformatf("vec%0d fpu_req_o", i), fpu_req_o, vt[i].e_req);
            chk($sformatf("vec%0d core_gnt_o", i), core_gnt_o, vt[i].e_gnt);
            chk($sformatf("vec%0d core_rvalid_o", i), core_rvalid_o, vt[i].e_rv);
            chk($sformatf("vec%0d busy_o", i), busy_o, vt[i].e_busy);
            if (vt[i].e_rv) begin
                chk($sformatf("vec%0d core_rdata_o", i), core_rdata_o, vt[i].e_d);
                chk($sformatf("vec%0d core_rID_o", i), core_rID_o, vt[i].e_id);
            end
            tick();
        end
    endtask

    initial begin
        logic [IW-1:0] got_ids[$];
        int due_q[$];
        int now;
        bit rv;

        //            req gnt rv rr  d             id   e_req e_gnt e_rv e_busy e_d           e_id
        vt[0] = '{1, 1, 0, 0, 32'h0,        9'd0, 1, 1, 0, 0, 32'h0,        9'd0};
        vt[1] = '{0, 0, 0, 0, 32'h0,        9'd0, 0, 0, 0, 1, 32'h0,        9'd0};
        vt[2] = '{0, 0, 0, 0, 32'h0,        9'd0, 0, 0, 0, 1, 32'h0,        9'd0};
        vt[3] = '{0, 0, 1, 0, 32'h3F800000, 9'd5, 0, 0, 0, 1, 32'h0,        9'd0};
        vt[4] = '{0, 0, 0, 1, 32'h0,        9'd0, 0, 0, 1, 1, 32'h3F800000, 9'd5};
        vt[5] = '{0, 0, 0, 0, 32'h0,        9'd0, 0, 0, 0, 0, 32'h0,        9'd0};

        #2;
        do_reset();
        run_table();

        // Credit stall: four accepts with the core not draining.
        for (int i = 0; i < 4; i++) cyc(1, 1, 0, 0, 0);
        drive(1, 1, 0, '0, '0, '0, 0);
        chk("stall fpu_req_o", fpu_req_o, 0);
        chk("stall core_gnt_o", core_gnt_o, 0);
        tick();
        for (int i = 1; i <= 4; i++) cyc(1, 1, 1, IW'(i), 0);
        drive(1, 1, 0, '0, '0, '0, 1);
        chk("stall pop-cycle core_gnt_o", core_gnt_o, 0);
        tick();
        drive(1, 1, 0, '0, '0, '0, 0);
        chk("reopen core_gnt_o", core_gnt_o, 1);
        chk("reopen fpu_req_o", fpu_req_o, 1);
        tick();
        cyc(0, 0, 1, 9'd20, 1);
        for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 1);
        chk("stall drained busy_o", busy_o, 0);

        // Ordering and pointer wrap with interleaved pops.
        do_reset();
        got_ids.delete();
        for (int k = 0; k <= 8; k++) begin
            drive(k <= 5, k <= 5, (k >= 1 && k <= 6), DW'(k), FW'(k), IW'(k), k >= 2);
            if (core_rvalid_o && core_rready_i) got_ids.push_back(core_rID_o);
            tick();
        end
        chk("order count", got_ids.size(), 6);
        for (int i = 0; i < 6 && i < got_ids.size(); i++)
            chk($sformatf("order id%0d", i), got_ids[i], i + 1);
        chk("order overflow_o", overflow_o, 0);

        // Push and pop together on a full buffer.
        do_reset();
        for (int i = 0; i < 4; i++) cyc(1, 1, 0, 0, 0);
        for (int i = 1; i <= 4; i++) cyc(0, 0, 1, IW'(i), 0);
        drive(0, 0, 1, 32'h4000_0005, 5'd5, 9'd5, 1);
        chk("full pushpop head", core_rID_o, 1);
        tick();
        drive(0, 0, 0, '0, '0, '0, 0);
        chk("full pushpop still valid", core_rvalid_o, 1);
        chk("full pushpop new head", core_rID_o, 2);
        chk("full pushpop overflow_o", overflow_o, 0);
        tick();
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 1);

        // Dropped push on a full buffer sets a sticky error.
        do_reset();
        for (int i = 0; i < 4; i++) cyc(1, 1, 0, 0, 0);
        for (int i = 1; i <= 4; i++) cyc(0, 0, 1, IW'(i), 0);
        cyc(0, 0, 1, 9'd99, 0);
        drive(0, 0, 0, '0, '0, '0, 0);
        chk("drop overflow_o", overflow_o, 1);
        tick();
        for (int i = 0; i < 6; i++) cyc(0, 0, 0, 0, 1);
        chk("drop sticky overflow_o", overflow_o, 1);
        chk("drop empty rvalid", core_rvalid_o, 0);

        // Reset mid-operation: occupancy 3, inflight 4.
        for (int i = 0; i < 4; i++) cyc(1, 1, 0, 0, 0);
        for (int i = 1; i <= 3; i++) cyc(0, 0, 1, IW'(i), 0);
        do_reset();
        run_table();

        // Randomized traffic: one response per accepted request, 1..4 cycles later.
        now = 0;
        for (int c = 0; c < 3000; c++) begin
            rv = (due_q.size() != 0) && (due_q[0] <= now);
            if (rv) void'(due_q.pop_front());
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, rv,
                  DW'($urandom), FW'($urandom), IW'($urandom), $urandom_range(0, 2) != 0);
            if (m_last_acc) due_q.push_back(now + int'($urandom_range(1, 4)));
            tick();
            now++;
        end
        for (int c = 0; c < 40; c++) begin
            rv = (due_q.size() != 0) && (due_q[0] <= now);
            if (rv) void'(due_q.pop_front());
            drive(0, 0, rv, DW'($urandom), FW'($urandom), IW'($urandom), 1);
            tick();
            now++;
        end
        chk("random end busy_o", busy_o, 0);
        chk("random end overflow_o", overflow_o, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
